// File: rtl/xadc_drp_sequencer_pkg.sv
// Shared definitions for the XADC DRP sequencer and the AXI register file that exposes net_out.
// Holds the FSM encoding, DRP widths and the net_out field layout.
package xadc_drp_sequencer_pkg;

    localparam int DRP_ADDR_W  = 7;
    localparam int DRP_DATA_W  = 16;
    localparam int SAMPLE_W    = 12;
    localparam int CH_IDX_W    = 4;
    localparam int CNT_W       = 16;

    localparam int NET_W           = 32;
    localparam int NET_SPIKE_LSB   = 0;
    localparam int NET_SPIKE_W     = 4;
    localparam int NET_TIMEOUT_BIT = 7;
    localparam int NET_COUNT_LSB   = 16;
    localparam int NET_COUNT_W     = 16;
    localparam int SPIKE_IDX_W     = $clog2(NET_SPIKE_W);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_RDY,
        ST_STORE,
        ST_GAP
    } seq_state_e;

    function automatic logic [NET_W-1:0] pack_net_out(
        input logic [NET_SPIKE_W-1:0] spike_vec,
        input logic                   timeout_err,
        input logic [NET_COUNT_W-1:0] sweep_count
    );
        logic [NET_W-1:0] word;
        word = '0;
        word[NET_SPIKE_LSB +: NET_SPIKE_W] = spike_vec;
        word[NET_TIMEOUT_BIT]              = timeout_err;
        word[NET_COUNT_LSB +: NET_COUNT_W] = sweep_count;
        return word;
    endfunction

endpackage

// File: rtl/drp_timeout_counter.sv
// Loadable down-counter with a sticky-at-zero expired flag.
// Shared between the drdy timeout and the inter-sweep gap count.
module drp_timeout_counter
    import xadc_drp_sequencer_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         S_AXI_ACLK,
    input  logic         rst,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_value,
    output logic         expired
);

    logic [W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge S_AXI_ACLK) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/xadc_drp_sequencer.sv
// Sweeps N_CH XADC auxiliary channels over DRP, captures 12-bit samples, flags threshold
// spikes and read timeouts, and publishes status as the net_out word.
module xadc_drp_sequencer
    import xadc_drp_sequencer_pkg::*;
#(
    parameter int                    N_CH      = 4,
    parameter logic [DRP_ADDR_W-1:0] BASE_ADDR = 7'h10,
    parameter int                    TIMEOUT   = 255
) (
    input  logic                  S_AXI_ACLK,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [CNT_W-1:0]      period,
    input  logic [SAMPLE_W-1:0]   threshold,
    input  logic                  err_clr,
    output logic [DRP_ADDR_W-1:0] daddr,
    output logic                  den,
    output logic                  dwe,
    output logic [DRP_DATA_W-1:0] di,
    input  logic [DRP_DATA_W-1:0] do_data,
    input  logic                  drdy,
    output logic [SAMPLE_W-1:0]   sample,
    output logic [CH_IDX_W-1:0]   sample_ch,
    output logic                  sample_valid,
    output logic [NET_W-1:0]      net_out,
    output logic                  sweep_done
);

    localparam logic [CH_IDX_W-1:0] LAST_IDX     = CH_IDX_W'(N_CH - 1);
    localparam logic [CNT_W-1:0]    TIMEOUT_LOAD = CNT_W'(TIMEOUT - 1);

    seq_state_e             state, next_state;
    logic [CH_IDX_W-1:0]    idx;
    logic                   rd_ok;
    logic [NET_SPIKE_W-1:0] spike_vec;
    logic [NET_COUNT_W-1:0] sweep_count;
    logic                   timeout_err;
    logic                   cnt_load, cnt_dec, cnt_expired;
    logic [CNT_W-1:0]       cnt_value;
    logic                   last_ch, rd_done, rd_timeout;
    logic                   unused_drp_lsbs;

    drp_timeout_counter #(.W(CNT_W)) u_counter (
        .S_AXI_ACLK (S_AXI_ACLK),
        .rst        (rst),
        .load       (cnt_load),
        .dec        (cnt_dec),
        .load_value (cnt_value),
        .expired    (cnt_expired)
    );

    assign last_ch    = (idx == LAST_IDX);
    assign rd_done    = (state == ST_WAIT_RDY) && drdy;
    assign rd_timeout = (state == ST_WAIT_RDY) && !drdy && cnt_expired;

    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    always_comb begin
        next_state   = state;
        den          = 1'b0;
        sample_valid = 1'b0;
        sweep_done   = 1'b0;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        cnt_value    = TIMEOUT_LOAD;
        case (state)
            ST_IDLE: begin
                if (enable) next_state = ST_REQ;
            end
            ST_REQ: begin
                den        = 1'b1;
                cnt_load   = 1'b1;
                next_state = ST_WAIT_RDY;
            end
            ST_WAIT_RDY: begin
                cnt_dec = 1'b1;
                if (rd_done || rd_timeout) next_state = ST_STORE;
            end
            ST_STORE: begin
                sample_valid = rd_ok;
                sweep_done   = last_ch;
                if (!enable) begin
                    next_state = ST_IDLE;
                end else if (last_ch && (period != '0)) begin
                    // GAP counts down to zero, so it lasts exactly period cycles.
                    next_state = ST_GAP;
                    cnt_load   = 1'b1;
                    cnt_value  = period - CNT_W'(1);
                end else begin
                    next_state = ST_REQ;
                end
            end
            ST_GAP: begin
                cnt_dec = 1'b1;
                if (!enable)          next_state = ST_IDLE;
                else if (cnt_expired) next_state = ST_REQ;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (rst) begin
            state       <= ST_IDLE;
            idx         <= '0;
            rd_ok       <= 1'b0;
            sample      <= '0;
            sample_ch   <= '0;
            spike_vec   <= '0;
            sweep_count <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= next_state;
            if (state == ST_WAIT_RDY) rd_ok <= drdy;
            if (rd_done) begin
                sample    <= do_data[DRP_DATA_W-1 -: SAMPLE_W];
                sample_ch <= idx;
            end
            if (state == ST_IDLE) begin
                idx <= '0;
            end else if (state == ST_STORE) begin
                idx <= last_ch ? '0 : idx + CH_IDX_W'(1);
                if (last_ch) sweep_count <= sweep_count + NET_COUNT_W'(1);
                if (rd_ok && (idx < CH_IDX_W'(NET_SPIKE_W)))
                    spike_vec[idx[SPIKE_IDX_W-1:0]] <= (sample >= threshold);
            end
            // A timeout landing with err_clr keeps the error visible.
            if (rd_timeout)   timeout_err <= 1'b1;
            else if (err_clr) timeout_err <= 1'b0;
        end
    end

    assign daddr           = BASE_ADDR + DRP_ADDR_W'(idx);
    assign dwe             = 1'b0;
    assign di              = '0;
    assign net_out         = pack_net_out(spike_vec, timeout_err, sweep_count);
    assign unused_drp_lsbs = ^do_data[DRP_DATA_W-SAMPLE_W-1:0];

endmodule

// File: tb/tb_xadc_drp_sequencer.sv
// Self-checking bench for xadc_drp_sequencer: DRP responder, event monitor and a sweep-level model.
module tb_xadc_drp_sequencer;

    localparam int         N_CH      = 4;
    localparam logic [6:0] BASE_ADDR = 7'h10;
    localparam int         TIMEOUT   = 255;

    logic        clk = 1'b0;
    logic        rst, enable, err_clr, den, dwe, drdy, sample_valid, sweep_done;
    logic [15:0] period, di, do_data;
    logic [11:0] threshold, sample;
    logic [6:0]  daddr;
    logic [3:0]  sample_ch;
    logic [31:0] net_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    xadc_drp_sequencer #(.N_CH(N_CH), .BASE_ADDR(BASE_ADDR), .TIMEOUT(TIMEOUT)) dut (
        .S_AXI_ACLK   (clk),
        .rst          (rst),
        .enable       (enable),
        .period       (period),
        .threshold    (threshold),
        .err_clr      (err_clr),
        .daddr        (daddr),
        .den          (den),
        .dwe          (dwe),
        .di           (di),
        .do_data      (do_data),
        .drdy         (drdy),
        .sample       (sample),
        .sample_ch    (sample_ch),
        .sample_valid (sample_valid),
        .net_out      (net_out),
        .sweep_done   (sweep_done)
    );

    // Responder configuration (written by tests) and monitor log (written only by the monitor).
    logic [15:0] resp_data  [N_CH];
    int          resp_delay [N_CH];   // 0 means the channel never answers

    typedef struct {
        logic [3:0]  ch;
        logic [11:0] smp;
        int          lat;
    } ev_t;

    int         cyc = 0;
    int         den_count = 0;
    int         done_cnt = 0;
    int         done_cyc = 0;
    int         last_den_cyc = 0;
    int         den_cyc_q[$];
    logic [6:0] den_addr_q[$];
    ev_t        ev_q[$];

    // Sweep-level reference model.
    logic [3:0]  model_spike;
    logic        model_err;
    logic [15:0] model_count;

    initial begin : responder_monitor
        int          rsp_cnt;
        logic [15:0] rsp_val;
        int          ch;
        ev_t         e;
        rsp_cnt = 0;
        rsp_val = '0;
        drdy    = 1'b0;
        do_data = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (den === 1'b1) begin
                den_count++;
                last_den_cyc = cyc;
                den_cyc_q.push_back(cyc);
                den_addr_q.push_back(daddr);
            end
            if (sample_valid === 1'b1) begin
                e.ch  = sample_ch;
                e.smp = sample;
                e.lat = cyc - last_den_cyc;
                ev_q.push_back(e);
            end
            if (sweep_done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            drdy    = 1'b0;
            do_data = 16'($urandom);
            if (rsp_cnt > 0) begin
                rsp_cnt--;
                if (rsp_cnt == 0) begin
                    drdy    = 1'b1;
                    do_data = rsp_val;
                end
            end
            if (den === 1'b1) begin
                ch      = int'(daddr) - int'(BASE_ADDR);
                rsp_cnt = 0;
                if (ch >= 0 && ch < N_CH && resp_delay[ch] > 0) begin
                    rsp_cnt = resp_delay[ch];
                    rsp_val = resp_data[ch];
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick(1);
            if (done_cnt >= target) begin ok = 1'b1; return; end
        end
    endtask

    task automatic wait_den(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick(1);
            if (den_count >= target) begin ok = 1'b1; return; end
        end
    endtask

    task automatic wait_ev(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick(1);
            if (ev_q.size() >= target) begin ok = 1'b1; return; end
        end
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        enable  = 1'b0;
        err_clr = 1'b0;
        tick(2);
        rst = 1'b0;
        model_spike = '0;
        model_err   = 1'b0;
        model_count = '0;
        tick(1);
    endtask

    task automatic config_uniform(input logic [15:0] data, input int delay);
        for (int c = 0; c < N_CH; c++) begin
            resp_data[c]  = data;
            resp_delay[c] = delay;
        end
    endtask

    task automatic model_sweep();
        for (int c = 0; c < N_CH; c++) begin
            if (resp_delay[c] > 0) model_spike[c] = (resp_data[c][15:4] >= threshold);
            else                   model_err = 1'b1;
        end
        model_count++;
    endtask

    function automatic logic [31:0] exp_net();
        return {model_count, 8'h00, model_err, 3'b000, model_spike};
    endfunction

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; err_clr = 1'b0; period = '0; threshold = '0;
        tick(3);
        checks++; if (den !== 1'b0)          begin errors++; $display("FAIL reset_den: got %b expected 0", den); end
        checks++; if (daddr !== BASE_ADDR)   begin errors++; $display("FAIL reset_daddr: got %h expected %h", daddr, BASE_ADDR); end
        checks++; if ({sample, sample_ch} !== 16'h0) begin errors++; $display("FAIL reset_sample: got %h/%h expected 0/0", sample, sample_ch); end
        checks++; if ({sample_valid, sweep_done} !== 2'b00) begin errors++; $display("FAIL reset_strobes: got %b expected 00", {sample_valid, sweep_done}); end
        checks++; if (net_out !== 32'h0)     begin errors++; $display("FAIL reset_net_out: got %h expected 0", net_out); end
        checks++; if ({dwe, di} !== 17'h0)   begin errors++; $display("FAIL reset_dwe_di: got %b/%h expected 0/0", dwe, di); end
        enable = 1'b0;
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_basic_sweep();
        bit ok;
        int ev_base, den_base;
        do_reset();
        config_uniform(16'h8000, 1);
        threshold = 12'h7FF; period = '0;
        ev_base = ev_q.size(); den_base = den_count;
        enable = 1'b1;
        wait_done(done_cnt + 1, 100, ok);
        enable = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL basic_sweep_done: got timeout expected sweep_done"); end
        model_sweep();
        tick(2);
        checks++; if (ev_q.size() - ev_base != N_CH) begin errors++; $display("FAIL basic_valid_count: got %0d expected %0d", ev_q.size() - ev_base, N_CH); end
        for (int i = 0; i < N_CH && ev_base + i < ev_q.size(); i++) begin
            checks++;
            if (ev_q[ev_base+i].ch !== 4'(i) || ev_q[ev_base+i].smp !== 12'h800 || ev_q[ev_base+i].lat != 2) begin
                errors++;
                $display("FAIL basic_event%0d: got ch%0d/%h/lat%0d expected ch%0d/800/lat2", i, ev_q[ev_base+i].ch, ev_q[ev_base+i].smp, ev_q[ev_base+i].lat, i);
            end
            checks++;
            if (den_addr_q[den_base+i] !== BASE_ADDR + 7'(i)) begin
                errors++; $display("FAIL basic_daddr%0d: got %h expected %h", i, den_addr_q[den_base+i], BASE_ADDR + 7'(i));
            end
        end
        checks++; if (net_out !== 32'h0001_000F) begin errors++; $display("FAIL basic_net_out: got %h expected 0001000f", net_out); end
    endtask

    task automatic test_spike_pattern();
        bit ok;
        do_reset();
        config_uniform(16'hFFF0, 2);
        resp_data[2] = 16'h1000;
        threshold = 12'h200; period = 16'd3;
        enable = 1'b1;
        wait_done(done_cnt + 1, 100, ok);
        enable = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL spike_done: got timeout expected sweep_done"); end
        model_sweep();
        tick(2);
        checks++; if (net_out[3:0] !== 4'b1011) begin errors++; $display("FAIL spike_vec: got %b expected 1011", net_out[3:0]); end
        checks++; if (net_out !== exp_net())     begin errors++; $display("FAIL spike_net_out: got %h expected %h", net_out, exp_net()); end
    endtask

    task automatic test_timeout();
        bit ok;
        int ev_base, den_base;
        do_reset();
        for (int c = 0; c < N_CH; c++) begin
            resp_data[c]  = 16'($urandom);
            resp_delay[c] = 1;
        end
        resp_delay[1] = 0;
        threshold = 12'($urandom); period = '0;
        ev_base = ev_q.size(); den_base = den_count;
        enable = 1'b1;
        wait_den(den_base + 2, 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL timeout_den1: got timeout expected den for channel 1"); end
        // err_clr coincides with the expiring cycle; the timeout must win.
        tick(TIMEOUT);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        wait_done(done_cnt + 1, 50, ok);
        enable = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL timeout_done: got timeout expected sweep_done"); end
        model_sweep();
        tick(2);
        if (den_cyc_q.size() >= den_base + 3) begin
            checks++;
            if (den_cyc_q[den_base+2] - den_cyc_q[den_base+1] != TIMEOUT + 2) begin
                errors++; $display("FAIL timeout_den_gap: got %0d expected %0d", den_cyc_q[den_base+2] - den_cyc_q[den_base+1], TIMEOUT + 2);
            end
        end
        checks++;
        if (ev_q.size() - ev_base != 3 || ev_q[ev_base].ch !== 4'd0 || ev_q[ev_base+1].ch !== 4'd2 || ev_q[ev_base+2].ch !== 4'd3) begin
            errors++; $display("FAIL timeout_valid_channels: got %0d events expected channels 0,2,3", ev_q.size() - ev_base);
        end
        checks++; if (net_out !== exp_net()) begin errors++; $display("FAIL timeout_net_out: got %h expected %h", net_out, exp_net()); end
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        model_err = 1'b0;
        tick(1);
        checks++; if (net_out !== exp_net()) begin errors++; $display("FAIL timeout_err_clr: got %h expected %h", net_out, exp_net()); end
    endtask

    task automatic test_period();
        bit ok;
        int den_base, d1, d2;
        do_reset();
        config_uniform(16'h4560, 1);
        threshold = 12'h400; period = 16'd100;
        den_base = den_count;
        enable = 1'b1;
        wait_done(done_cnt + 1, 100, ok);
        d1 = done_cyc;
        tick(1);
        period = 16'd7;   // already latched for this gap; applies to the next one
        wait_done(done_cnt + 1, 300, ok);
        d2 = done_cyc;
        wait_done(done_cnt + 1, 100, ok);
        enable = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL period_done: got timeout expected three sweeps"); end
        model_sweep(); model_sweep(); model_sweep();
        tick(2);
        if (den_cyc_q.size() >= den_base + 9) begin
            checks++; if (den_cyc_q[den_base+4] - d1 != 101) begin errors++; $display("FAIL period_gap100: got %0d expected 101", den_cyc_q[den_base+4] - d1); end
            checks++; if (den_cyc_q[den_base+8] - d2 != 8)   begin errors++; $display("FAIL period_gap7: got %0d expected 8", den_cyc_q[den_base+8] - d2); end
        end
        checks++; if (net_out !== exp_net()) begin errors++; $display("FAIL period_net_out: got %h expected %h", net_out, exp_net()); end
    endtask

    task automatic test_enable_stop();
        bit ok;
        int ev_base, den_base;
        do_reset();
        for (int c = 0; c < N_CH; c++) resp_data[c] = 16'($urandom);
        config_uniform(16'h0, 1);
        for (int c = 0; c < N_CH; c++) resp_data[c] = 16'($urandom);
        threshold = 12'($urandom); period = '0;
        den_base = den_count;
        enable = 1'b1;
        wait_done(done_cnt + 1, 100, ok);
        enable = 1'b0;
        model_sweep();
        tick(20);
        checks++; if (den_count - den_base != N_CH) begin errors++; $display("FAIL stop_in_store: got %0d dens expected %0d", den_count - den_base, N_CH); end
        // Second run: drop enable while the first read is outstanding.
        for (int c = 0; c < N_CH; c++) resp_delay[c] = 10;
        ev_base = ev_q.size(); den_base = den_count;
        enable = 1'b1;
        wait_den(den_base + 1, 10, ok);
        tick(1);
        enable = 1'b0;
        wait_ev(ev_base + 1, 30, ok);
        checks++;
        if (!ok || ev_q[ev_base].ch !== 4'd0 || ev_q[ev_base].lat != 11 || ev_q[ev_base].smp !== resp_data[0][15:4]) begin
            errors++; $display("FAIL stop_read_completes: got ok=%0d expected ch0 sample %h latency 11", ok, resp_data[0][15:4]);
        end
        model_spike[0] = (resp_data[0][15:4] >= threshold);
        tick(30);
        checks++; if (den_count - den_base != 1) begin errors++; $display("FAIL stop_no_more_den: got %0d dens expected 1", den_count - den_base); end
        // Restart after a mid-sweep stop must begin at channel 0 and keep the status word.
        for (int c = 0; c < N_CH; c++) resp_delay[c] = 1;
        den_base = den_count;
        enable = 1'b1;
        wait_den(den_base + 1, 10, ok);
        checks++; if (!ok || den_addr_q[den_base] !== BASE_ADDR) begin errors++; $display("FAIL restart_channel0: got ok=%0d daddr expected %h", ok, BASE_ADDR); end
        wait_done(done_cnt + 1, 50, ok);
        enable = 1'b0;
        model_sweep();
        tick(2);
        checks++; if (net_out !== exp_net()) begin errors++; $display("FAIL restart_net_out: got %h expected %h", net_out, exp_net()); end
    endtask

    task automatic test_reset_mid_read();
        bit ok;
        int ev_base, den_base;
        do_reset();
        config_uniform(16'hABC0, 1);
        threshold = 12'h100; period = '0;
        enable = 1'b1;
        wait_done(done_cnt + 1, 100, ok);
        enable = 1'b0;
        tick(5);
        resp_delay[0] = 4;
        ev_base = ev_q.size(); den_base = den_count;
        enable = 1'b1;
        wait_den(den_base + 1, 10, ok);
        tick(1);
        rst = 1'b1;
        enable = 1'b0;
        tick(1);
        rst = 1'b0;
        tick(10);
        checks++; if (ev_q.size() != ev_base) begin errors++; $display("FAIL rst_late_drdy_valid: got %0d events expected 0", ev_q.size() - ev_base); end
        checks++; if (den_count - den_base != 1) begin errors++; $display("FAIL rst_no_den: got %0d dens expected 1", den_count - den_base); end
        checks++; if ({den, daddr} !== {1'b0, BASE_ADDR}) begin errors++; $display("FAIL rst_drp_outputs: got den=%b daddr=%h expected 0/%h", den, daddr, BASE_ADDR); end
        checks++; if ({sample, sample_ch, sample_valid, sweep_done} !== 18'h0) begin errors++; $display("FAIL rst_sample_outputs: got %h/%h/%b/%b expected zeros", sample, sample_ch, sample_valid, sweep_done); end
        checks++; if (net_out !== 32'h0) begin errors++; $display("FAIL rst_net_out: got %h expected 0", net_out); end
    endtask

    task automatic test_random();
        bit ok;
        int ev_base, den_base, d1, k;
        for (int it = 0; it < 4; it++) begin
            do_reset();
            for (int c = 0; c < N_CH; c++) begin
                resp_data[c]  = 16'($urandom);
                resp_delay[c] = int'($urandom_range(1, 4));
            end
            threshold = (it == 0) ? resp_data[1][15:4] : 12'($urandom);
            period    = 16'($urandom_range(0, 6));
            ev_base = ev_q.size(); den_base = den_count;
            enable = 1'b1;
            wait_done(done_cnt + 1, 100, ok);
            d1 = done_cyc;
            wait_done(done_cnt + 1, 100, ok);
            enable = 1'b0;
            checks++; if (!ok) begin errors++; $display("FAIL rand%0d_done: got timeout expected two sweeps", it); end
            model_sweep(); model_sweep();
            tick(2);
            checks++; if (ev_q.size() - ev_base != 2 * N_CH) begin errors++; $display("FAIL rand%0d_valid_count: got %0d expected %0d", it, ev_q.size() - ev_base, 2 * N_CH); end
            for (int i = 0; i < 2 * N_CH && ev_base + i < ev_q.size(); i++) begin
                k = i % N_CH;
                checks++;
                if (ev_q[ev_base+i].ch !== 4'(k) || ev_q[ev_base+i].smp !== resp_data[k][15:4] || ev_q[ev_base+i].lat != resp_delay[k] + 1) begin
                    errors++;
                    $display("FAIL rand%0d_event%0d: got ch%0d/%h/lat%0d expected ch%0d/%h/lat%0d", it, i, ev_q[ev_base+i].ch, ev_q[ev_base+i].smp, ev_q[ev_base+i].lat, k, resp_data[k][15:4], resp_delay[k] + 1);
                end
            end
            if (den_cyc_q.size() > den_base + N_CH) begin
                checks++;
                if (den_cyc_q[den_base+N_CH] - d1 != int'(period) + 1) begin
                    errors++; $display("FAIL rand%0d_gap: got %0d expected %0d", it, den_cyc_q[den_base+N_CH] - d1, int'(period) + 1);
                end
            end
            checks++; if (net_out !== exp_net()) begin errors++; $display("FAIL rand%0d_net_out: got %h expected %h", it, net_out, exp_net()); end
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; err_clr = 1'b0; period = '0; threshold = '0;
        for (int c = 0; c < N_CH; c++) begin
            resp_data[c]  = '0;
            resp_delay[c] = 1;
        end
        test_reset();
        test_basic_sweep();
        test_spike_pattern();
        test_timeout();
        test_period();
        test_enable_stop();
        test_reset_mid_read();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion expected finish within 1 ms");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/xadc_drp_sequencer.md
XADC_DRP_SEQUENCER -- requirements
Module: xadc_drp_sequencer

Interface
REQ-001 Parameter N_CH, default 4: number of auxiliary channels swept, 1..16.
REQ-002 Parameter BASE_ADDR, default 7'h10: DRP address of VAUX0; channel k is read at BASE_ADDR+k.
REQ-003 Parameter TIMEOUT, default 255: maximum cycles waited for drdy per read.
REQ-004 S_AXI_ACLK  in  1  sole clock; all logic on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 enable  in  1  level; 1 runs continuous sweeps, 0 stops at the next safe point.
REQ-007 period  in  16  idle cycles between the end of one sweep and the start of the next.
REQ-008 threshold  in  12  spike threshold, compared against the 12-bit sample.
REQ-009 err_clr  in  1  one-cycle pulse clearing the sticky timeout error.
REQ-010 daddr  out  7  DRP address; den out 1 DRP enable pulse; dwe out 1 tied 0; di out 16 tied 0.
REQ-011 do_data  in  16  DRP read data; drdy in 1 DRP read-complete strobe.
REQ-012 sample  out  12  last captured sample, do_data[15:4]; sample_ch out 4 its channel index; sample_valid out 1 one-cycle strobe.
REQ-013 net_out  out  32  network output word: [3:0] spike_vec, [7] timeout_err, [31:16] sweep_count, other bits 0.
REQ-014 sweep_done  out  1  one-cycle strobe when the last channel of a sweep is stored.

Function
REQ-015 FSM states IDLE, REQ, WAIT_RDY, STORE, GAP; IDLE on reset.
REQ-016 IDLE -> REQ when enable=1, channel index reset to 0.
REQ-017 REQ: den=1 for exactly one cycle with daddr=BASE_ADDR+idx, dwe=0; next state WAIT_RDY.
REQ-018 daddr shall hold its value from REQ until the read completes or times out.
REQ-019 WAIT_RDY: on drdy=1 capture do_data[15:4] into sample and enter STORE; drdy in any other state is ignored.
REQ-020 WAIT_RDY: if drdy is absent for TIMEOUT cycles after den, set timeout_err, hold previous sample, enter STORE without sample_valid.
REQ-021 STORE (one cycle): on successful read, sample_valid=1, sample_ch=idx, spike_vec[idx] = (sample >= threshold), unsigned.
REQ-022 STORE: if idx = N_CH-1, idx wraps to 0, sweep_done=1, sweep_count increments (0xFFFF wraps to 0), next GAP; else idx+1, next REQ.
REQ-023 GAP: count period cycles then REQ; period=0 gives REQ on the cycle after STORE; period is sampled on GAP entry.
REQ-024 enable=0 is honoured only in IDLE, GAP or STORE, returning to IDLE; an outstanding read (REQ/WAIT_RDY) always completes or times out first.
REQ-025 Re-enable after a stop starts a fresh sweep at channel 0; spike_vec and sweep_count are retained.
REQ-026 err_clr clears timeout_err; a timeout in the same cycle wins (bit remains 1).
REQ-027 Minimum latency den -> sample_valid: 2 cycles when drdy arrives the cycle after den.

Reset
REQ-028 rst=1 forces IDLE, idx=0, den=0, daddr=BASE_ADDR, sample=0, sample_ch=0, sample_valid=0, sweep_done=0, net_out=0.
REQ-029 rst mid-transaction abandons the read; a later drdy from that read is ignored because the FSM is not in WAIT_RDY.

Structure
REQ-030 Shared package holds the FSM state enum, DRP address/width constants and the net_out field bit positions, reused by the AXI register file.
REQ-031 One sub-module, drp_timeout_counter (load, decrement, expired flag), reused for the GAP period count.

Verification
REQ-032 DRP model drdy 1 cycle after den, do_data = {12'h800,4'h0} all channels, threshold=12'h7FF, period=0 -> 4 sample_valid at ch 0..3, spike_vec=4'hF, sweep_count=1 after first sweep_done.
REQ-033 Channel 2 returns 12'h100, others 12'hFFF, threshold=12'h200 -> net_out[3:0]=4'b1011.
REQ-034 Model never asserts drdy for channel 1 -> den to next den gap = TIMEOUT+2 cycles, net_out[7]=1, no sample_valid for ch 1; err_clr pulse then net_out[7]=0.
REQ-035 period=100 -> exactly 100 cycles with den=0 between sweep_done and next den; 0xFFFF sweeps -> sweep_count wraps to 0.
REQ-036 enable dropped during WAIT_RDY (drdy delayed 10 cycles) -> read completes, sample_valid fires, FSM returns to IDLE, no further den.
REQ-037 rst asserted in WAIT_RDY, late drdy 3 cycles later -> all outputs at reset values, no sample_valid.
